key_load_ctrl: RTL and testbench

KEY_LOAD_CTRL -- requirements
Module: key_load_ctrl

---
 rtl/key_ctrl_pkg.sv | 17 +
 rtl/key_load_ctrl.sv | 131 +++++++++++++
 tb/tb_key_load_ctrl.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/key_ctrl_pkg.sv
// key_ctrl_pkg: constants shared by the key-load controller and its users.
//   - Header opcodes (3-bit field taken from the top of a header word).
//   - FSM state encoding, kept as plain localparam constants so existing
//     code that compares against raw state values keeps working.
package key_ctrl_pkg;

    // Header opcodes
    localparam logic [2:0] OP_LOAD_KEY  = 3'd0;
    localparam logic [2:0] OP_SET_SLICE = 3'd1;

    // FSM state encoding
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_LOAD      = 2'd1;
    localparam logic [1:0] ST_SLICE_ARG = 2'd2;
    localparam logic [1:0] ST_DONE      = 2'd3;

endpackage

// File: rtl/key_load_ctrl.sv
// key_load_ctrl: decodes a header/data word stream and loads keys into a
// slotted key store, or sets a slice selector.
//
// Ports:
//   clock          - sole clock, rising edge
//   reset          - asynchronous, active-high reset
//   instrValid     - instruct holds a valid word
//   instrReady     - block accepts a word this cycle (low only in DONE)
//   instruct       - header or data word
//   out            - registered key word to the key store
//   writeEnableKey - one-hot slot write strobe, aligned with out
//   keyWordIdx     - index of the word on out (0 = first loaded)
//   sliceSelector  - registered slice selection
//   done           - one-cycle pulse when a command completes
//   err            - one-cycle pulse on a rejected word or command
module key_load_ctrl
    import key_ctrl_pkg::*;
#(
    parameter int WORD_W    = 32,
    parameter int KEY_WORDS = 4,
    parameter int KEY_SLOTS = 6,
    parameter int SEL_W     = 5
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 instrValid,
    output logic                 instrReady,
    input  logic [WORD_W-1:0]    instruct,
    output logic [WORD_W-1:0]    out,
    output logic [KEY_SLOTS-1:0] writeEnableKey,
    output logic [2:0]           keyWordIdx,
    output logic [SEL_W-1:0]     sliceSelector,
    output logic                 done,
    output logic                 err
);

    logic [1:0]           state;
    logic [3:0]           slot;
    logic [2:0]           cnt;
    logic                 accept;
    logic                 is_header;
    logic [2:0]           opcode;
    logic [3:0]           operand;
    logic                 slot_ok;
    logic                 last_word;
    logic [KEY_SLOTS-1:0] slot_onehot;

    assign instrReady = (state != ST_DONE);
    assign accept     = instrValid & instrReady;
    assign is_header  = instruct[WORD_W-1];
    assign opcode     = instruct[WORD_W-2:WORD_W-4];
    assign operand    = instruct[3:0];
    assign slot_ok    = ({1'b0, operand} < 5'(KEY_SLOTS));
    assign last_word  = (cnt == 3'(KEY_WORDS - 1));

    always_comb begin
        slot_onehot = '0;
        for (int unsigned i = 0; i < KEY_SLOTS; i++) begin
            slot_onehot[i] = (slot == 4'(i));
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= ST_IDLE;
            slot           <= '0;
            cnt            <= '0;
            out            <= '0;
            writeEnableKey <= '0;
            keyWordIdx     <= '0;
            sliceSelector  <= '0;
            done           <= 1'b0;
            err            <= 1'b0;
        end else begin
            // Strobes default low; each is raised for the single cycle
            // following the event that causes it.
            writeEnableKey <= '0;
            done           <= 1'b0;
            err            <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        if (!is_header) begin
                            err <= 1'b1;
                        end else begin
                            case (opcode)
                                OP_LOAD_KEY: begin
                                    if (slot_ok) begin
                                        slot  <= operand;
                                        cnt   <= '0;
                                        state <= ST_LOAD;
                                    end else begin
                                        err <= 1'b1;
                                    end
                                end
                                OP_SET_SLICE: state <= ST_SLICE_ARG;
                                default:      err   <= 1'b1;
                            endcase
                        end
                    end
                end
                ST_LOAD: begin
                    // Data words are taken verbatim, MSB included.
                    if (accept) begin
                        out            <= instruct;
                        writeEnableKey <= slot_onehot;
                        keyWordIdx     <= cnt;
                        cnt            <= 3'(cnt + 3'd1);
                        if (last_word) begin
                            state <= ST_DONE;
                            done  <= 1'b1;
                        end
                    end
                end
                ST_SLICE_ARG: begin
                    if (accept) begin
                        sliceSelector <= instruct[SEL_W-1:0];
                        state         <= ST_DONE;
                        done          <= 1'b1;
                    end
                end
                default: begin
                    // DONE: done is high for exactly this cycle.
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_key_load_ctrl.sv
// Bench for key_load_ctrl: a default build (6 slots, 4 words) and a wide
// build (16 slots, 8 words) share clock and reset.
module tb_key_load_ctrl;

    typedef struct packed {
        logic [31:0] d;
        logic [15:0] we;
        logic [2:0]  idx;
        logic [31:0] cyc;
    } rec_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [31:0] cyc = '0;
    always @(posedge clk) cyc <= cyc + 32'd1;

    // default build
    logic        v0 = 1'b0;
    logic [31:0] i0 = '0;
    logic        r0;
    logic [31:0] o0;
    logic [5:0]  we0;
    logic [2:0]  idx0;
    logic [4:0]  sel0;
    logic        d0, e0;

    // wide build
    logic        v1 = 1'b0;
    logic [31:0] i1 = '0;
    logic        r1;
    logic [31:0] o1;
    logic [15:0] we1;
    logic [2:0]  idx1;
    logic [4:0]  sel1;
    logic        d1, e1;

    key_load_ctrl dut (
        .clock(clk), .reset(rst), .instrValid(v0), .instrReady(r0),
        .instruct(i0), .out(o0), .writeEnableKey(we0), .keyWordIdx(idx0),
        .sliceSelector(sel0), .done(d0), .err(e0)
    );

    key_load_ctrl #(.WORD_W(32), .KEY_WORDS(8), .KEY_SLOTS(16), .SEL_W(5)) dut8 (
        .clock(clk), .reset(rst), .instrValid(v1), .instrReady(r1),
        .instruct(i1), .out(o1), .writeEnableKey(we1), .keyWordIdx(idx1),
        .sliceSelector(sel1), .done(d1), .err(e1)
    );

    int checks = 0;
    int errors = 0;

    rec_t exp0[$], obs0[$], exp1[$], obs1[$];
    int done0_cnt = 0, err0_cnt = 0, done1_cnt = 0, err1_cnt = 0;

    // Monitor: records every strobe with its cycle and counts pulses.
    always @(negedge clk) begin
        if (we0 !== '0) obs0.push_back({o0, 16'(we0), idx0, cyc});
        if (we1 !== '0) obs1.push_back({o1, we1, idx1, cyc});
        if (d0 === 1'b1) done0_cnt++;
        if (e0 === 1'b1) err0_cnt++;
        if (d1 === 1'b1) done1_cnt++;
        if (e1 === 1'b1) err1_cnt++;
    end

    // Drive one word; when it is a data word the expected strobe record is
    // queued for the cycle right after acceptance.
    task automatic send(input int which, input logic [31:0] w, input bit data,
                        input logic [15:0] we, input logic [2:0] idx);
        int unsigned n = 0;
        @(negedge clk);
        if (which == 0) begin v0 = 1'b1; i0 = w; end
        else begin v1 = 1'b1; i1 = w; end
        while (((which == 0) ? r0 : r1) !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++; errors++;
            $display("FAIL ready_timeout: instrReady got 0 expected 1 (word %h)", w);
        end
        if (data) begin
            if (which == 0) exp0.push_back({w, we, idx, cyc + 32'd1});
            else exp1.push_back({w, we, idx, cyc + 32'd1});
        end
        @(posedge clk);
        #1;
        v0 = 1'b0;
        v1 = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        idle(2);
        checks++; if (o0 !== '0)    begin errors++; $display("FAIL rst_out: got %h expected 0", o0); end
        checks++; if (we0 !== '0)   begin errors++; $display("FAIL rst_we: got %b expected 0", we0); end
        checks++; if (idx0 !== '0)  begin errors++; $display("FAIL rst_idx: got %0d expected 0", idx0); end
        checks++; if (sel0 !== '0)  begin errors++; $display("FAIL rst_sel: got %0d expected 0", sel0); end
        checks++; if ({d0, e0} !== 2'b00) begin errors++; $display("FAIL rst_done_err: got %b expected 00", {d0, e0}); end
        checks++; if (r0 !== 1'b1)  begin errors++; $display("FAIL rst_ready: got %b expected 1", r0); end
        checks++; if ({o1, we1, idx1, sel1, d1, e1} !== '0) begin errors++; $display("FAIL rst_wide: got nonzero outputs expected 0"); end
        #1 rst = 1'b0;
        idle(1);
    endtask

    task automatic test_load;
        logic [31:0] words [4] = '{32'he0318a99, 32'h23f247b3, 32'hed8ff212, 32'hef0bc156};
        rec_t e, o;
        int dc = done0_cnt;
        send(0, 32'h80000000, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) send(0, words[i], 1'b1, 16'h0001, 3'(i));
        @(negedge clk);
        checks++; if (d0 !== 1'b1) begin errors++; $display("FAIL load_done_pulse: got %b expected 1", d0); end
        checks++; if (r0 !== 1'b0) begin errors++; $display("FAIL load_ready_in_done: got %b expected 0", r0); end
        idle(3);
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            checks++;
            if (obs0.size() == 0) begin errors++; $display("FAIL load_missing: got none expected %h", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin errors++; $display("FAIL load_write: got %h expected %h", o, e); end end
        end
        checks++; if (obs0.size() != 0) begin errors++; $display("FAIL load_extra: got %0d strobes expected 0", obs0.size()); end
        obs0.delete();
        checks++; if (done0_cnt - dc != 1) begin errors++; $display("FAIL load_done_count: got %0d expected 1", done0_cnt - dc); end
        checks++; if (sel0 !== '0) begin errors++; $display("FAIL load_sel_kept: got %0d expected 0", sel0); end
    endtask

    task automatic test_reject;
        int ec = err0_cnt;
        send(0, 32'h80000007, 1'b0, '0, '0);
        idle(2);
        checks++; if (err0_cnt - ec != 1) begin errors++; $display("FAIL rej_slot: err got %0d expected 1", err0_cnt - ec); end
        send(0, 32'h00000004, 1'b0, '0, '0);
        idle(2);
        checks++; if (err0_cnt - ec != 2) begin errors++; $display("FAIL rej_nomsb: err got %0d expected 2", err0_cnt - ec); end
        send(0, 32'ha0000000, 1'b0, '0, '0);
        idle(2);
        checks++; if (err0_cnt - ec != 3) begin errors++; $display("FAIL rej_opcode: err got %0d expected 3", err0_cnt - ec); end
        checks++; if (obs0.size() != 0) begin errors++; $display("FAIL rej_strobe: got %0d strobes expected 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_slice;
        int dc = done0_cnt;
        int ec = err0_cnt;
        send(0, 32'h90000000, 1'b0, '0, '0);
        send(0, 32'h00000004, 1'b0, '0, '0);
        idle(3);
        checks++; if (sel0 !== 5'd4) begin errors++; $display("FAIL slice_sel: got %0d expected 4", sel0); end
        checks++; if (done0_cnt - dc != 1) begin errors++; $display("FAIL slice_done: got %0d expected 1", done0_cnt - dc); end
        checks++; if (err0_cnt != ec) begin errors++; $display("FAIL slice_err: got %0d expected 0", err0_cnt - ec); end
        checks++; if (obs0.size() != 0) begin errors++; $display("FAIL slice_strobe: got %0d strobes expected 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_gaps;
        rec_t e, o;
        send(0, 32'h80000005, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) begin
            idle(3);
            send(0, $urandom, 1'b1, 16'h0020, 3'(i));
        end
        idle(4);
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            checks++;
            if (obs0.size() == 0) begin errors++; $display("FAIL gaps_missing: got none expected %h", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin errors++; $display("FAIL gaps_write: got %h expected %h", o, e); end end
        end
        checks++; if (obs0.size() != 0) begin errors++; $display("FAIL gaps_extra: got %0d strobes expected 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_reset_midload;
        rec_t e, o;
        send(0, 32'h80000000, 1'b0, '0, '0);
        send(0, $urandom, 1'b1, 16'h0001, 3'd0);
        send(0, $urandom, 1'b1, 16'h0001, 3'd1);
        @(negedge clk);
        #1 rst = 1'b1;
        #1;
        checks++; if ({o0, we0, idx0, sel0, d0, e0} !== '0) begin errors++; $display("FAIL midrst_outputs: got %h expected 0", {o0, we0, idx0, sel0, d0, e0}); end
        idle(3);
        checks++; if (obs0.size() != 2) begin errors++; $display("FAIL midrst_partial: got %0d strobes expected 2", obs0.size()); end
        #1 rst = 1'b0;
        exp0.delete();
        obs0.delete();
        send(0, 32'h80000001, 1'b0, '0, '0);
        for (int i = 0; i < 4; i++) send(0, $urandom, 1'b1, 16'h0002, 3'(i));
        idle(4);
        while (exp0.size() > 0) begin
            e = exp0.pop_front();
            checks++;
            if (obs0.size() == 0) begin errors++; $display("FAIL midrst_missing: got none expected %h", e); end
            else begin o = obs0.pop_front(); if (o !== e) begin errors++; $display("FAIL midrst_write: got %h expected %h", o, e); end end
        end
        checks++; if (obs0.size() != 0) begin errors++; $display("FAIL midrst_extra: got %0d strobes expected 0", obs0.size()); end
        obs0.delete();
    endtask

    task automatic test_wide;
        rec_t e, o;
        int dc = done1_cnt;
        send(1, 32'h8000000f, 1'b0, '0, '0);
        for (int i = 0; i < 8; i++) send(1, $urandom, 1'b1, 16'h8000, 3'(i));
        idle(4);
        while (exp1.size() > 0) begin
            e = exp1.pop_front();
            checks++;
            if (obs1.size() == 0) begin errors++; $display("FAIL wide_missing: got none expected %h", e); end
            else begin o = obs1.pop_front(); if (o !== e) begin errors++; $display("FAIL wide_write: got %h expected %h", o, e); end end
        end
        checks++; if (obs1.size() != 0) begin errors++; $display("FAIL wide_extra: got %0d strobes expected 0", obs1.size()); end
        checks++; if (done1_cnt - dc != 1) begin errors++; $display("FAIL wide_done: got %0d expected 1", done1_cnt - dc); end
        obs1.delete();
    endtask

    initial begin
        test_reset();
        test_load();
        test_reject();
        test_slice();
        test_gaps();
        test_reset_midload();
        test_wide();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
